// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl: adds or subtracts two N-bit signed operands through one 4-bit slice, one nibble per cycle, LSB first
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 overflow,
  output logic                 cout,
  output logic                 busy
);
  localparam int N = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  logic [1:0] state;
  logic [N-1:0] ra, rb;
  logic carry;
  logic [IW-1:0] idx;
  logic [NIBBLES-1:0][3:0] sq;
  logic [4:0] s;
  // operands shift right so the active nibble is always the low one
  assign s = {1'b0, ra[3:0]} + {1'b0, rb[3:0]} + {4'd0, carry};
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign sum = sq;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      carry <= 1'b0;
      idx <= '0;
      sq <= '0;
      overflow <= 1'b0;
      cout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra <= a;
          rb <= b ^ {N{sub}};
          carry <= sub;
          idx <= '0;
          state <= RUN;
        end
        RUN: begin
          sq[idx] <= s[3:0];
          carry <= s[4];
          ra <= ra >> 4;
          rb <= rb >> 4;
          idx <= idx == LAST ? '0 : idx + IW'(1);
          if (idx == LAST) begin
            cout <= s[4];
            overflow <= (ra[3] & rb[3] & ~s[3]) | (~ra[3] & ~rb[3] & s[3]);
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// tb_nibble_serial_addsub_ctrl: directed corners and random traffic on 4- and 1-nibble instances against an arithmetic model
module tb_nibble_serial_addsub_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic iv4, ir4, sb4, vo4, or4, ovf4, co4, bz4;
  logic [15:0] a4, b4, sum4;
  logic iv1, ir1, sb1, vo1, or1, ovf1, co1, bz1;
  logic [3:0] a1, b1, sum1;
  int checks = 0, failures = 0;

  nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .sub(sb4),
    .out_valid(vo4), .out_ready(or4), .sum(sum4), .overflow(ovf4), .cout(co4), .busy(bz4));
  nibble_serial_addsub_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .sub(sb1),
    .out_valid(vo1), .out_ready(or1), .sum(sum1), .overflow(ovf1), .cout(co1), .busy(bz1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s, input int n,
                                output logic [63:0] sm, output logic o, output logic c);
    logic [63:0] mask, bb, full;
    logic sa, sbb, ss;
    mask = (64'd1 << n) - 1;
    bb = s ? (~b & mask) : b;
    full = a + bb + {63'd0, s};
    c = full[n];
    sm = full & mask;
    sa = a[n-1];
    sbb = b[n-1];
    ss = sm[n-1];
    o = s ? (sa != sbb && ss != sa) : (sa == sbb && ss != sa);
  endfunction

  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic s, input int hold,
                     output logic [15:0] rs, output logic ro, output logic rc);
    int n;
    a4 = a; b4 = b; sb4 = s; iv4 = 1'b1;
    n = 0;
    while (!ir4 && n < 50) begin @(negedge clk); n++; end
    chk("in_ready4", ir4, 1);
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0; a4 = 16'($urandom); b4 = 16'($urandom); sb4 = 1'($urandom);
    n = 0;
    while (!vo4 && n < 20) begin @(negedge clk); n++; end
    chk("latency4", n, 4);
    rs = sum4; ro = ovf4; rc = co4;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_sum4", sum4, rs);
      chk("hold_flags4", {ovf4, co4}, {ro, rc});
      chk("hold_ready4", {ir4, vo4}, 2'b01);
    end
    or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
    chk("idle_after4", {ir4, vo4, bz4}, 3'b100);
  endtask

  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic s);
    int n;
    logic [63:0] es;
    logic eo, ec;
    logic [3:0] hs;
    a1 = a; b1 = b; sb1 = s; iv1 = 1'b1;
    n = 0;
    while (!ir1 && n < 50) begin @(negedge clk); n++; end
    chk("in_ready1", ir1, 1);
    @(posedge clk);
    @(negedge clk);
    a1 = 4'($urandom); b1 = 4'($urandom); sb1 = 1'($urandom);
    n = 0;
    while (!vo1 && n < 20) begin @(negedge clk); n++; end
    chk("latency1", n, 1);
    model({60'd0, a}, {60'd0, b}, s, 4, es, eo, ec);
    chk("sum1", sum1, es);
    chk("flags1", {ovf1, co1}, {eo, ec});
    hs = sum1;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("hold_sum1", sum1, hs);
    end
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    chk("idle_after1", ir1, 1);
  endtask

  initial begin
    logic [15:0] rs, ra, rb;
    logic ro, rc, rsub;
    logic [63:0] es;
    logic eo, ec;
    rst_n = 1'b0;
    iv4 = 0; or4 = 0; a4 = 0; b4 = 0; sb4 = 0;
    iv1 = 0; or1 = 0; a1 = 0; b1 = 0; sb1 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_out4", {sum4, ovf4, co4, vo4, bz4, ir4}, {16'h0, 5'b00001});
    chk("reset_out1", {sum1, ovf1, co1, vo1, bz1, ir1}, {4'h0, 5'b00001});
    rst_n = 1'b1;
    @(negedge clk);
    op4(16'h7FFF, 16'h0001, 1'b0, 0, rs, ro, rc);
    chk("t1", {rs, ro, rc}, {16'h8000, 2'b10});
    op4(16'h8000, 16'h0001, 1'b1, 0, rs, ro, rc);
    chk("t2", {rs, ro, rc}, {16'h7FFF, 2'b11});
    op4(16'hFFFF, 16'h0001, 1'b0, 0, rs, ro, rc);
    chk("t3a", {rs, ro, rc}, {16'h0000, 2'b01});
    op4(16'h1234, 16'h1234, 1'b1, 0, rs, ro, rc);
    chk("t3b", {rs, ro, rc}, {16'h0000, 2'b01});
    op4(16'h1234, 16'h1111, 1'b0, 5, rs, ro, rc);
    chk("t4", {rs, ro, rc}, {16'h2345, 2'b00});
    a4 = 16'h1111; b4 = 16'h2222; sb4 = 1'b0; iv4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_reset", {sum4, ovf4, co4, vo4, bz4, ir4}, {16'h0, 5'b00001});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op4(16'h0003, 16'h0004, 1'b0, 0, rs, ro, rc);
    chk("t5", {rs, ro, rc}, {16'h0007, 2'b00});
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rsub = 1'($urandom);
      if (i < 4) begin ra = i[0] ? 16'h8000 : 16'h7FFF; rb = i[1] ? 16'h8000 : 16'h7FFF; end
      op4(ra, rb, rsub, $urandom_range(0, 2), rs, ro, rc);
      model({48'd0, ra}, {48'd0, rb}, rsub, 16, es, eo, ec);
      chk("rand_sum4", rs, es);
      chk("rand_flags4", {ro, rc}, {eo, ec});
    end
    op1(4'h7, 4'h1, 1'b0);
    chk("t6", {sum1, ovf1}, {4'h8, 1'b1});
    op1(4'h8, 4'h1, 1'b1);
    op1(4'h8, 4'h8, 1'b0);
    op1(4'h0, 4'h8, 1'b1);
    op1(4'hF, 4'h1, 1'b0);
    for (int i = 0; i < 100; i++) op1(4'($urandom), 4'($urandom), 1'($urandom));
    iv1 = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
